// File: rtl/ycrcb2rgb.sv
// rtl/ycrcb2rgb.sv - 3-stage pipelined YCbCr to RGB converter with back-pressure and clip counter
//
// Converts one 8-bit YCbCr pixel per cycle to 8-bit RGB using signed Q14
// coefficients. There are three register stages:
//   S1: latch Y/Cb/Cr
//   S2: multiply-accumulate
//   S3: round, clamp and register the output
// All three stages shift together only when the output side can move.
//
// Optional feature: define YCRCB2RGB_CLIP_CNT_EN to build the clip detector
// and the saturating clip event counter. With the macro undefined,
// clip_count is tied to zero.
//
// Parameters:
//   CNT_W       width of the clip event counter
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   enable      input pixel valid
//   data_in     {Cr[23:16], Cb[15:8], Y[7:0]}
//   in_ready    block accepts data_in this cycle
//   data_out    {B[23:16], G[15:8], R[7:0]}
//   enable_out  data_out valid
//   out_ready   downstream accepts data_out this cycle
//   clip_count  pixels with at least one clamped component (saturating)

module ycrcb2rgb #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [23:0]      data_in,
    output logic             in_ready,
    output logic [23:0]      data_out,
    output logic             enable_out,
    input  logic             out_ready,
    output logic [CNT_W-1:0] clip_count
);

    // Q14 conversion coefficients
    localparam logic signed [15:0] KR_CR = 16'sd22970;
    localparam logic signed [15:0] KG_CB = 16'sd5638;
    localparam logic signed [15:0] KG_CR = 16'sd11700;
    localparam logic signed [15:0] KB_CB = 16'sd29032;

    // The whole pipeline moves as one unit. It moves whenever the output
    // register is empty or is being drained this cycle. An empty output
    // register therefore never blocks upstream.
    logic advance;
    assign advance  = !enable_out || out_ready;
    assign in_ready = advance;

    // ------------------------------------------------------------------
    // S1: input latch
    // ------------------------------------------------------------------
    logic       s1_valid;
    logic [7:0] s1_y;
    logic [7:0] s1_cb;
    logic [7:0] s1_cr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_y     <= 8'd0;
            s1_cb    <= 8'd0;
            s1_cr    <= 8'd0;
        end else if (advance) begin
            s1_valid <= enable;
            // Only load data when the pixel is valid. Bubble cycles then
            // leave the datapath registers untouched.
            if (enable) begin
                s1_y  <= data_in[7:0];
                s1_cb <= data_in[15:8];
                s1_cr <= data_in[23:16];
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: multiply-accumulate at 26-bit signed width
    // ------------------------------------------------------------------
    logic signed [8:0]  cb_off;
    logic signed [8:0]  cr_off;
    logic signed [25:0] y_sh;
    logic signed [25:0] r_mac;
    logic signed [25:0] g_mac;
    logic signed [25:0] b_mac;

    assign cb_off = $signed({1'b0, s1_cb}) - 9'sd128;
    assign cr_off = $signed({1'b0, s1_cr}) - 9'sd128;
    assign y_sh   = $signed({4'b0000, s1_y, 14'b0});

    // Each product fits in 24 bits. The worst-case sum stays below 2^23,
    // so 26 bits leaves headroom and nothing overflows.
    assign r_mac = y_sh + KR_CR * cr_off;
    assign g_mac = y_sh - KG_CB * cb_off - KG_CR * cr_off;
    assign b_mac = y_sh + KB_CB * cb_off;

    logic               s2_valid;
    logic signed [25:0] s2_r;
    logic signed [25:0] s2_g;
    logic signed [25:0] s2_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_r     <= 26'sd0;
            s2_g     <= 26'sd0;
            s2_b     <= 26'sd0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_r <= r_mac;
                s2_g <= g_mac;
                s2_b <= b_mac;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: round, clamp, output register
    // ------------------------------------------------------------------

    // Round half up, then floor-shift by 14 (arithmetic shift).
    function automatic logic signed [25:0] round_q14(input logic signed [25:0] acc);
        logic signed [25:0] rnd;
        rnd = acc + 26'sd8192;
        return rnd >>> 14;
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [25:0] acc);
        logic signed [25:0] q;
        q = round_q14(acc);
        if (q < 26'sd0) begin
            return 8'd0;
        end else if (q > 26'sd255) begin
            return 8'd255;
        end else begin
            return q[7:0];
        end
    endfunction

    logic [7:0] r_px;
    logic [7:0] g_px;
    logic [7:0] b_px;

    assign r_px = clamp8(s2_r);
    assign g_px = clamp8(s2_g);
    assign b_px = clamp8(s2_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_out <= 1'b0;
            data_out   <= 24'd0;
        end else if (advance) begin
            enable_out <= s2_valid;
            if (s2_valid) begin
                data_out <= {b_px, g_px, r_px};
            end
        end
    end

    // ------------------------------------------------------------------
    // Clip event counter
    // ------------------------------------------------------------------
`ifdef YCRCB2RGB_CLIP_CNT_EN
    function automatic logic is_clip(input logic signed [25:0] acc);
        logic signed [25:0] q;
        q = round_q14(acc);
        return (q < 26'sd0) || (q > 26'sd255);
    endfunction

    logic clip_any;
    assign clip_any = s2_valid && (is_clip(s2_r) || is_clip(s2_g) || is_clip(s2_b));

    // Count a pixel at the moment it loads into the output register.
    // A stalled pixel is therefore counted exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_count <= {CNT_W{1'b0}};
        end else if (advance && clip_any && (clip_count != {CNT_W{1'b1}})) begin
            clip_count <= clip_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign clip_count = {CNT_W{1'b0}};
`endif

endmodule
